// File: rtl/ysyx_22041412_decode_stage_pkg.sv
// ysyx_22041412_decode_stage_pkg: opcode values and out_type codes shared by the decode stage
package ysyx_22041412_decode_stage_pkg;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_W  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R_W    = 7'b0111011;
  typedef enum logic [3:0] {
    T_NONE   = 4'b0000,
    T_IALU   = 4'b0001,
    T_UPPER  = 4'b0010,
    T_BRANCH = 4'b0011,
    T_STORE  = 4'b0100,
    T_R      = 4'b0101,
    T_LOAD   = 4'b1001,
    T_JUMP   = 4'b1011,
    T_MUL    = 4'b1111
  } itype_t;
endpackage

// File: rtl/ysyx_22041412_imm_gen.sv
// ysyx_22041412_imm_gen: combinational RISC-V format, immediate, word-op and legality decode
module ysyx_22041412_imm_gen
  import ysyx_22041412_decode_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [3:0]      itype,
  output logic [XLEN-1:0] imm,
  output logic            is_w,
  output logic            illegal
);
  logic [6:0]  op;
  logic        w_op;
  itype_t      t;
  logic [31:0] i32;
  assign op   = instr[6:0];
  assign w_op = (op == OP_IMM_W) || (op == OP_R_W);
  always_comb begin
    t = (op == OP_IMM || op == OP_IMM_W) ? T_IALU :
        (op == OP_LOAD) ? T_LOAD :
        (op == OP_JALR || op == OP_JAL || op == OP_SYSTEM) ? T_JUMP :
        (op == OP_LUI || op == OP_AUIPC) ? T_UPPER :
        (op == OP_BRANCH) ? T_BRANCH :
        (op == OP_STORE) ? T_STORE :
        (op == OP_R || op == OP_R_W) ? (instr[25] ? T_MUL : T_R) : T_NONE;
    illegal = (instr[1:0] != 2'b11) || (t == T_NONE) || (XLEN == 32 && w_op);
    // system shares the J layout so its upper bits reach execute as an offset
    i32 = illegal ? 32'd0 :
          (op == OP_IMM || op == OP_IMM_W || op == OP_LOAD || op == OP_JALR) ?
            {{20{instr[31]}}, instr[31:20]} :
          (op == OP_LUI || op == OP_AUIPC) ? {instr[31:12], 12'b0} :
          (op == OP_JAL || op == OP_SYSTEM) ?
            {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
          (op == OP_BRANCH) ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
          (op == OP_STORE) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} : 32'd0;
  end
  assign imm   = XLEN'($signed(i32));
  assign is_w  = (XLEN == 64) && w_op;
  assign itype = illegal ? T_NONE : t;
endmodule

// File: rtl/ysyx_22041412_decode_stage.sv
// ysyx_22041412_decode_stage: instruction queue feeding a registered decode output stage
module ysyx_22041412_decode_stage
  import ysyx_22041412_decode_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_func3,
  output logic                     out_func7,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [3:0]               out_type,
  output logic                     out_is_w,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, load;
  logic [31:0]     head;
  logic [3:0]      h_type;
  logic [XLEN-1:0] h_imm;
  logic            h_w, h_ill;
  assign head     = instr_q[rptr];
  // a pop never frees a slot for the same-edge push, so readiness only watches occupancy
  assign in_ready = (count != (AW+1)'(DEPTH)) && rst_n;
  assign push     = in_valid && in_ready;
  assign load     = (count != '0) && (!out_valid || out_ready);
  ysyx_22041412_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (head),
    .itype   (h_type),
    .imm     (h_imm),
    .is_w    (h_w),
    .illegal (h_ill)
  );
  always_ff @(posedge clk)
    if (push && !flush) begin
      instr_q[wptr] <= in_instr;
      pc_q[wptr]    <= in_pc;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(load);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_func3   <= '0;
      out_func7   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_type    <= '0;
      out_is_w    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_pc      <= pc_q[rptr];
      out_opcode  <= head[6:0];
      out_func3   <= head[14:12];
      out_func7   <= head[30];
      out_rs1     <= head[19:15];
      out_rs2     <= head[24:20];
      out_rd      <= head[11:7];
      out_imm     <= h_imm;
      out_type    <= h_type;
      out_is_w    <= h_w;
      out_illegal <= h_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule
